// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: the frame FSM states,
// the word-length base and the stop-bit encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Data bits per frame are WORD_LEN_BASE + word_length (5..8).
    localparam int WORD_LEN_BASE = 5;

    // stop_bits pin encodings
    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    // Mask that keeps only the data bits used at a given word_length.
    function automatic logic [7:0] data_mask(input logic [1:0] wl);
        logic [7:0] m;
        m = '0;
        for (int k = 0; k < 8; k++) begin
            m[k] = (k < (WORD_LEN_BASE + int'(wl)));
        end
        return m;
    endfunction

endpackage

// File: rtl/transmitter.sv
// UART transmitter: start bit, 5..8 data bits LSB first, optional parity,
// one or two stop bits. The frame configuration is captured at accept, so pin
// changes during a frame only affect the next one. break_ctrl overrides the
// line level without disturbing the frame timing.
module transmitter
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  word_length,
    input  logic [15:0] baud_rate_cnt,
    input  logic        parity_en,
    input  logic        parity_even,
    input  logic        stop_bits,
    input  logic        break_ctrl,
    input  logic [7:0]  pi_tx_data,
    input  logic        pi_flag,
    output logic        tx,
    output logic        tx_ready,
    output logic        po_flag
);

    uart_state_e state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;   // 0..B-1 within the current bit
    logic [15:0] bm1_q, bm1_d;             // latched B-1 (B=0 behaves as B=1)
    logic [2:0]  bit_cnt_q, bit_cnt_d;     // data bit index, or stop bit index
    logic [7:0]  data_q, data_d;           // shift register, bit 0 is on the line
    logic [1:0]  wl_q, wl_d;
    logic        par_en_q, par_en_d;
    logic        par_q, par_d;             // parity bit, precomputed at accept
    logic        stop_q, stop_d;
    logic        tx_q, tx_d;
    logic        po_q, po_d;

    logic        tick;
    logic [2:0]  last_data;
    logic [2:0]  last_stop;
    logic [7:0]  masked;
    logic        level;

    // Next-state logic for the frame FSM, counters, shifter and line level.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bm1_d      = bm1_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        wl_d       = wl_q;
        par_en_d   = par_en_q;
        par_d      = par_q;
        stop_d     = stop_q;
        po_d       = 1'b0;
        level      = 1'b1;
        masked     = pi_tx_data & data_mask(word_length);
        tick       = (baud_cnt_q == bm1_q);
        last_data  = {1'b0, wl_q} + 3'd4;
        last_stop  = 3'd0;

        case (stop_q)
            STOP_ONE: last_stop = 3'd0;
            STOP_TWO: last_stop = 3'd1;
        endcase

        // Counter runs through every non-idle bit and wraps at B-1.
        if (state_q != IDLE) begin
            baud_cnt_d = tick ? 16'd0 : baud_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (pi_flag) begin
                    state_d  = START;
                    data_d   = masked;
                    wl_d     = word_length;
                    par_en_d = parity_en;
                    par_d    = (^masked) ^ ~parity_even;
                    stop_d   = stop_bits;
                    bm1_d    = (baud_rate_cnt == 16'd0) ? 16'd0 : baud_rate_cnt - 16'd1;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == last_data) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        data_d    = data_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == last_stop) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                        po_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so tx is a clean register.
        case (state_d)
            IDLE:    level = 1'b1;
            START:   level = 1'b0;
            DATA:    level = data_d[0];
            PARITY:  level = par_d;
            STOP:    level = 1'b1;
            default: level = 1'b1;
        endcase

        tx_d = break_ctrl ? 1'b0 : level;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bm1_q      <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            wl_q       <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            stop_q     <= STOP_ONE;
            tx_q       <= 1'b1;
            po_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bm1_q      <= bm1_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            wl_q       <= wl_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            stop_q     <= stop_d;
            tx_q       <= tx_d;
            po_q       <= po_d;
        end
    end

    assign tx       = tx_q;
    assign po_flag  = po_q;
    assign tx_ready = (state_q == IDLE);

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for the UART transmitter: each frame pushes its expected
// per-cycle line/ready/done values into a scoreboard, which is drained and
// compared cycle by cycle.
module tb_transmitter;

    logic        clk;
    logic        rst;
    logic [1:0]  word_length;
    logic [15:0] baud_rate_cnt;
    logic        parity_en;
    logic        parity_even;
    logic        stop_bits;
    logic        break_ctrl;
    logic [7:0]  pi_tx_data;
    logic        pi_flag;
    logic        tx;
    logic        tx_ready;
    logic        po_flag;

    typedef struct {
        logic tx;
        logic rdy;
        logic po;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    transmitter dut (
        .clk           (clk),
        .rst           (rst),
        .word_length   (word_length),
        .baud_rate_cnt (baud_rate_cnt),
        .parity_en     (parity_en),
        .parity_even   (parity_even),
        .stop_bits     (stop_bits),
        .break_ctrl    (break_ctrl),
        .pi_tx_data    (pi_tx_data),
        .pi_flag       (pi_flag),
        .tx            (tx),
        .tx_ready      (tx_ready),
        .po_flag       (po_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference frame: start, W data bits LSB first, parity, stops; each bit B cycles,
    // followed by the completion cycle (idle, ready, done pulse).
    task automatic push_frame(input logic [1:0] wl, input int b, input logic pe,
                              input logic pev, input logic s2, input logic [7:0] data);
        logic bits[$];
        logic p;
        int   bb;
        int   w;
        exp_t e;
        bb = (b == 0) ? 1 : b;
        w  = 5 + int'(wl);
        p  = 1'b0;
        bits.push_back(1'b0);
        for (int k = 0; k < w; k++) begin
            bits.push_back(data[k]);
            p = p ^ data[k];
        end
        if (pe) bits.push_back(pev ? p : ~p);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < bb; c++) begin
                e.tx = bits[k]; e.rdy = 1'b0; e.po = 1'b0;
                sb.push_back(e);
            end
        end
        e.tx = 1'b1; e.rdy = 1'b1; e.po = 1'b1;
        sb.push_back(e);
    endtask

    task automatic start(input logic [1:0] wl, input int b, input logic pe,
                         input logic pev, input logic s2, input logic [7:0] data);
        @(negedge clk);
        word_length   = wl;
        baud_rate_cnt = 16'(b);
        parity_en     = pe;
        parity_even   = pev;
        stop_bits     = s2;
        pi_tx_data    = data;
        pi_flag       = 1'b1;
        push_frame(wl, b, pe, pev, s2, data);
    endtask

    // mode: 0 plain, 1 scramble config/data after accept, 2 hold pi_flag and switch data to 0x3C
    task automatic drain(input int mode, input int brk_on, input int brk_len, input int rst_at);
        int   i;
        exp_t e;
        logic etx;
        i = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e   = sb.pop_front();
            etx = e.tx;
            if (brk_on >= 0 && i > brk_on && i <= brk_on + brk_len) etx = 1'b0;
            chk("tx", tx, etx);
            chk("tx_ready", tx_ready, e.rdy);
            chk("po_flag", po_flag, e.po);
            if (i == 0) begin
                if (mode != 2) pi_flag = 1'b0;
                if (mode == 1) begin
                    word_length   = 2'($urandom_range(0, 3));
                    baud_rate_cnt = 16'($urandom_range(0, 20));
                    parity_en     = 1'($urandom_range(0, 1));
                    parity_even   = 1'($urandom_range(0, 1));
                    stop_bits     = 1'($urandom_range(0, 1));
                    pi_tx_data    = 8'($urandom);
                end
                if (mode == 2) pi_tx_data = 8'h3C;
            end
            if (sb.size() == 0) pi_flag = 1'b0;
            if (i == brk_on) break_ctrl = 1'b1;
            if (brk_on >= 0 && i == brk_on + brk_len) break_ctrl = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                sb.delete();
            end
            i++;
        end
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_tx", tx, 1'b1);
            chk("idle_ready", tx_ready, 1'b1);
            chk("idle_po", po_flag, 1'b0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        word_length   = 2'd3;
        baud_rate_cnt = 16'd4;
        parity_en     = 1'b0;
        parity_even   = 1'b0;
        stop_bits     = 1'b0;
        break_ctrl    = 1'b0;
        pi_tx_data    = 8'h00;
        pi_flag       = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        idle_check(2);
        rst = 1'b0;
        idle_check(2);

        // 8N1, B=4, 0x55; inputs scrambled after accept
        start(2'd3, 4, 1'b0, 1'b0, 1'b0, 8'h55);
        drain(1, -1, 0, -1);
        idle_check(2);

        // 5 bits, even parity, B=2, 0x1F (upper bits ignored)
        start(2'd0, 2, 1'b1, 1'b1, 1'b0, 8'hFF);
        drain(1, -1, 0, -1);
        idle_check(1);

        // 7 bits, odd parity, two stops, B=3, 0x00
        start(2'd2, 3, 1'b1, 1'b0, 1'b1, 8'h00);
        drain(1, -1, 0, -1);
        idle_check(1);

        // B=0 behaves as B=1, 6 bits, odd parity
        start(2'd1, 0, 1'b1, 1'b0, 1'b0, 8'hB6);
        drain(0, -1, 0, -1);
        idle_check(1);

        // back-to-back with pi_flag held: 0xA5 then 0x3C, B=1, one idle cycle between
        start(2'd3, 1, 1'b0, 1'b0, 1'b0, 8'hA5);
        push_frame(2'd3, 1, 1'b0, 1'b0, 1'b0, 8'h3C);
        drain(2, -1, 0, -1);
        idle_check(2);

        // break for 5 cycles inside the 2-stop-bit window, B=4; po_flag stays nominal
        start(2'd3, 4, 1'b0, 1'b0, 1'b1, 8'h96);
        drain(0, 36, 5, -1);
        idle_check(2);

        // reset in the middle of DATA, B=8
        start(2'd3, 8, 1'b0, 1'b0, 1'b0, 8'hC3);
        drain(0, -1, 0, 30);
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_po", po_flag, 1'b0);
        rst = 1'b0;
        idle_check(90);

        // pi_flag coincident with reset is discarded
        @(negedge clk);
        rst     = 1'b1;
        pi_flag = 1'b1;
        @(negedge clk);
        chk("rstflag_tx", tx, 1'b1);
        chk("rstflag_ready", tx_ready, 1'b1);
        rst     = 1'b0;
        pi_flag = 1'b0;
        idle_check(4);

        // clean frame after reset, B=8, 0x5A
        start(2'd3, 8, 1'b0, 1'b0, 1'b0, 8'h5A);
        drain(0, -1, 0, -1);
        idle_check(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
